// File: rtl/rtc_bus_scheduler_pkg.sv
// Shared encodings for the RTC bus scheduler: grant codes, FSM states and the
// released-bus pin pattern.
package rtc_sched_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_INIT = 2'b01,
        GNT_ESC  = 2'b10,
        GNT_LEER = 2'b11
    } grant_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        RUN   = 2'b10,
        GAP   = 2'b11
    } state_e;

    localparam logic [3:0] CTRL_IDLE = 4'b1111;

    // {a_d, cs, rd, wr}: the FPGA owns the data bus while selected and not reading.
    function automatic logic drives_bus(input logic [3:0] ctrl);
        return (ctrl[2] == 1'b0) && (ctrl[1] == 1'b1);
    endfunction

endpackage

// File: rtl/rtc_bus_scheduler_period_timer.sv
// Free-running period counter; tick is high for the one cycle in which the
// count sits at PERIOD-1, i.e. on the edge where it wraps.
module rtc_period_timer #(
    parameter logic [26:0] PERIOD = 27'd50_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [26:0] cnt_q;
    logic [26:0] cnt_d;
    logic        wrap_s;

    assign wrap_s = (cnt_q == (PERIOD - 27'd1));
    assign tick   = wrap_s;

    // Next count: wrap to zero at the end of the period.
    always_comb begin
        if (wrap_s) begin
            cnt_d = 27'd0;
        end else begin
            cnt_d = cnt_q + 27'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 27'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Arbitrates the shared RTC parallel bus between the INIT, ESC and LEER
// sequencers: latches requests, grants by fixed priority, muxes pins, times out.
module rtc_bus_scheduler
    import rtc_sched_pkg::*;
#(
    parameter logic [26:0] READ_PERIOD = 27'd50_000_000,
    parameter logic [8:0]  TIMEOUT     = 9'd300,
    parameter logic [3:0]  GAP_CYCLES  = 4'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_esc,
    output logic       go_init,
    output logic       go_esc,
    output logic       go_leer,
    input  logic       done_init,
    input  logic       done_esc,
    input  logic       done_leer,
    input  logic [3:0] ctrl_init,
    input  logic [3:0] ctrl_esc,
    input  logic [3:0] ctrl_leer,
    output logic       a_d,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic       bus_oe,
    output logic [1:0] grant,
    output logic       busy,
    output logic       err_timeout
);

    state_e      state_q;
    grant_e      grant_q;
    logic [8:0]  tmo_q;
    logic [3:0]  gap_q;
    logic        err_q;

    logic        pend_init_q, pend_esc_q, pend_leer_q;
    logic        pend_init_d, pend_esc_d, pend_leer_d;
    logic        tick_s;
    logic        idle_s, take_init_s, take_esc_s, take_leer_s;
    logic [3:0]  ctrl_sel_s;
    logic        done_sel_s;
    logic [3:0]  pins_s;

    rtc_period_timer #(
        .PERIOD (READ_PERIOD)
    ) u_period_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    assign idle_s      = (state_q == IDLE);
    assign take_init_s = idle_s && pend_init_q;
    assign take_esc_s  = idle_s && !pend_init_q && pend_esc_q;
    assign take_leer_s = idle_s && !pend_init_q && !pend_esc_q && pend_leer_q;

    // Pending flags: a grant to a slot clears it even if a new request arrives on that edge.
    always_comb begin
        pend_init_d = pend_init_q && !take_init_s;
        if (take_esc_s) begin
            pend_esc_d = 1'b0;
        end else begin
            pend_esc_d = pend_esc_q || req_esc;
        end
        if (take_leer_s) begin
            pend_leer_d = 1'b0;
        end else begin
            pend_leer_d = pend_leer_q || tick_s;
        end
    end

    // Pending flag registers; INIT is owed a run after every reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_init_q <= 1'b1;
            pend_esc_q  <= 1'b0;
            pend_leer_q <= 1'b0;
        end else begin
            pend_init_q <= pend_init_d;
            pend_esc_q  <= pend_esc_d;
            pend_leer_q <= pend_leer_d;
        end
    end

    // Scheduler FSM with grant, timeout, gap and sticky error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= GNT_NONE;
            tmo_q   <= 9'd0;
            gap_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take_init_s) begin
                        grant_q <= GNT_INIT;
                        state_q <= START;
                    end else if (take_esc_s) begin
                        grant_q <= GNT_ESC;
                        state_q <= START;
                    end else if (take_leer_s) begin
                        grant_q <= GNT_LEER;
                        state_q <= START;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                START: begin
                    tmo_q   <= 9'd0;
                    state_q <= RUN;
                end
                RUN: begin
                    if (done_sel_s) begin
                        gap_q   <= 4'd0;
                        state_q <= GAP;
                    end else if (tmo_q == (TIMEOUT - 9'd1)) begin
                        err_q   <= 1'b1;
                        gap_q   <= 4'd0;
                        state_q <= GAP;
                    end else begin
                        tmo_q <= tmo_q + 9'd1;
                    end
                end
                GAP: begin
                    if (gap_q == (GAP_CYCLES - 4'd1)) begin
                        grant_q <= GNT_NONE;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + 4'd1;
                    end
                end
                default: begin
                    grant_q <= GNT_NONE;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Route the granted sequencer's lines; only its done is honoured.
    always_comb begin
        case (grant_q)
            GNT_INIT: begin
                ctrl_sel_s = ctrl_init;
                done_sel_s = done_init;
            end
            GNT_ESC: begin
                ctrl_sel_s = ctrl_esc;
                done_sel_s = done_esc;
            end
            GNT_LEER: begin
                ctrl_sel_s = ctrl_leer;
                done_sel_s = done_leer;
            end
            default: begin
                ctrl_sel_s = CTRL_IDLE;
                done_sel_s = 1'b0;
            end
        endcase
        if ((state_q == START) || (state_q == RUN)) begin
            pins_s = ctrl_sel_s;
        end else begin
            pins_s = CTRL_IDLE;
        end
    end

    assign {a_d, cs, rd, wr} = pins_s;
    assign bus_oe      = (state_q == RUN) && drives_bus(pins_s);
    assign go_init     = (state_q == START) && (grant_q == GNT_INIT);
    assign go_esc      = (state_q == START) && (grant_q == GNT_ESC);
    assign go_leer     = (state_q == START) && (grant_q == GNT_LEER);
    assign grant       = grant_q;
    assign busy        = (state_q != IDLE);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Randomised bench for rtc_bus_scheduler: a timestamp-level reference model
// predicts each grant into a scoreboard; a monitor checks pins and pulses.
module tb_rtc_bus_scheduler;

    localparam int P  = 50;
    localparam int TO = 20;
    localparam int GP = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_esc = 1'b0;
    logic       go_init, go_esc, go_leer;
    logic       done_init = 1'b0, done_esc = 1'b0, done_leer = 1'b0;
    logic [3:0] ctrl_init = 4'hF, ctrl_esc = 4'hF, ctrl_leer = 4'hF;
    logic       a_d, cs, rd, wr, bus_oe;
    logic [1:0] grant;
    logic       busy, err_timeout;

    int errors = 0;
    int checks = 0;

    rtc_bus_scheduler #(
        .READ_PERIOD (27'd50),
        .TIMEOUT     (9'd20),
        .GAP_CYCLES  (4'd2)
    ) dut (
        .clk (clk), .reset (reset), .req_esc (req_esc),
        .go_init (go_init), .go_esc (go_esc), .go_leer (go_leer),
        .done_init (done_init), .done_esc (done_esc), .done_leer (done_leer),
        .ctrl_init (ctrl_init), .ctrl_esc (ctrl_esc), .ctrl_leer (ctrl_leer),
        .a_d (a_d), .cs (cs), .rd (rd), .wr (wr), .bus_oe (bus_oe),
        .grant (grant), .busy (busy), .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct { int who; int edge_n; } exp_t;
    exp_t sb_q[$];

    // Reference model: one owner at a time, described by start/exit edge numbers.
    int n_m, owner_m, t_start_m, t_exit_m;
    bit p_init, p_esc, p_leer, err_m, saw_to;
    int served [1:3];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ctrl_of(input int w);
        case (w)
            1: return ctrl_init;
            2: return ctrl_esc;
            3: return ctrl_leer;
            default: return 4'hF;
        endcase
    endfunction

    function automatic bit done_of(input int w);
        case (w)
            1: return done_init;
            2: return done_esc;
            3: return done_leer;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int who_of(input logic [2:0] g);
        case (g)
            3'b100: return 1;
            3'b010: return 2;
            3'b001: return 3;
            default: return 99;
        endcase
    endfunction

    function automatic void model_reset();
        n_m = 0; owner_m = 0; t_start_m = 0; t_exit_m = -1;
        p_init = 1'b1; p_esc = 1'b0; p_leer = 1'b0; err_m = 1'b0;
        sb_q.delete();
    endfunction

    function automatic void model_step();
        int granted;
        bit tick;
        granted = 0;
        n_m++;
        tick = ((n_m % P) == 0);
        if (owner_m != 0 && t_exit_m < 0) begin
            if (n_m >= t_start_m + 2) begin
                if (done_of(owner_m)) begin
                    t_exit_m = n_m;
                end else if (n_m == t_start_m + 1 + TO) begin
                    t_exit_m = n_m;
                    err_m = 1'b1;
                    saw_to = 1'b1;
                end
            end
        end else if (owner_m != 0) begin
            if (n_m == t_exit_m + GP) owner_m = 0;
        end else if (p_init || p_esc || p_leer) begin
            granted = p_init ? 1 : (p_esc ? 2 : 3);
            owner_m = granted;
            t_start_m = n_m;
            t_exit_m = -1;
            sb_q.push_back('{granted, n_m});
            if (granted == 1) p_init = 1'b0;
            if (granted == 2) p_esc = 1'b0;
            if (granted == 3) p_leer = 1'b0;
        end
        if (req_esc && granted != 2) p_esc = 1'b1;
        if (tick && granted != 3) p_leer = 1'b1;
    endfunction

    initial begin
        model_reset();
        saw_to = 1'b0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    // Monitor: pops the scoreboard on every go pulse, checks pins every cycle.
    initial begin
        logic [2:0] gov;
        logic [3:0] exp_pins;
        bit running;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            gov = {go_init, go_esc, go_leer};
            if (gov != 3'b000) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_go", gov, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("go_who", who_of(gov), e.who);
                    chk("go_edge", n_m, e.edge_n);
                    if (e.who >= 1 && e.who <= 3) served[e.who]++;
                end
            end else if (sb_q.size() > 0 && sb_q[0].edge_n <= n_m) begin
                e = sb_q.pop_front();
                chk("go_missing", 0, e.who);
            end
            running  = (owner_m != 0) && (t_exit_m < 0);
            exp_pins = running ? ctrl_of(owner_m) : 4'hF;
            chk("pins", {a_d, cs, rd, wr}, exp_pins);
            chk("bus_oe", bus_oe, int'(running && n_m > t_start_m && !exp_pins[2] && exp_pins[1]));
            chk("grant", grant, owner_m);
            chk("busy", busy, int'(owner_m != 0));
            chk("err_timeout", err_timeout, err_m);
        end
    end

    // Stimulus: random requests and control lines, emulated sequencers, resets.
    initial begin
        int rem, resp_who, hold, rst_cnt;
        bit esc_rst_done;
        rem = 0; resp_who = 0; hold = 0; rst_cnt = 0; esc_rst_done = 1'b0;
        served[1] = 0; served[2] = 0; served[3] = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            done_init = ($urandom_range(0, 99) < 3);
            done_esc  = ($urandom_range(0, 99) < 3);
            done_leer = ($urandom_range(0, 99) < 3);
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    if (resp_who == 1) done_init = 1'b1;
                    if (resp_who == 2) done_esc  = 1'b1;
                    if (resp_who == 3) done_leer = 1'b1;
                end
            end
            if (go_init || go_esc || go_leer) begin
                resp_who = who_of({go_init, go_esc, go_leer});
                rem = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 22));
            end
            ctrl_init = 4'($urandom_range(0, 15));
            ctrl_esc  = 4'($urandom_range(0, 15));
            ctrl_leer = 4'($urandom_range(0, 15));
            if (hold == 0 && $urandom_range(0, 99) == 0) hold = $urandom_range(5, 30);
            if (hold > 0) begin
                hold--;
                req_esc = 1'b1;
            end else begin
                req_esc = ($urandom_range(0, 99) < 3);
            end
            if (c == 1500) rst_cnt = 3;
            if (c >= 2500 && !esc_rst_done && grant == 2'b10 && busy && !go_esc) begin
                rst_cnt = 2;
                hold = 40;
                req_esc = 1'b1;
                esc_rst_done = 1'b1;
            end
            if (rst_cnt > 0) begin
                rst_cnt--;
                reset = 1'b1;
                rem = 0;
            end else begin
                reset = 1'b0;
            end
        end
        @(negedge clk);
        #3;
        chk("sb_drain", sb_q.size(), 0);
        chk("init_served", int'(served[1] > 0), 1);
        chk("esc_served", int'(served[2] > 0), 1);
        chk("leer_served", int'(served[3] > 0), 1);
        chk("timeout_exercised", int'(saw_to), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
